// File: rtl/word_to_serial_pkg.sv
// -----------------------------------------------------------------------------
// word_to_serial_pkg
// Shared types and helpers for the MSB-first word serializer.
//   state_t   : two-state FSM encoding (ST_IDLE, ST_SHIFT), 1 bit wide
//   cnt_width : bit-index counter width for a W-bit word (minimum 1)
// -----------------------------------------------------------------------------
package word_to_serial_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // A 1-bit word still needs a 1-bit counter; $clog2(1) would give 0.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/word_to_serial_buf.sv
// -----------------------------------------------------------------------------
// word_to_serial_buf
// One-entry holding register used by the prefetch build of the serializer.
// Holds a word accepted while the shifter is busy until the shifter drains it.
//   clk, rst  : clock, synchronous active-high reset
//   wr_en     : capture wr_data and mark the entry full
//   wr_data   : word to hold
//   rd_en     : entry consumed this cycle (ignored if wr_en is also high)
//   full      : entry holds a valid word
//   data      : held word
// -----------------------------------------------------------------------------
module word_to_serial_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic         full,
  output logic [W-1:0] data
);

  // A write in the same cycle as a read replaces the drained word, so the
  // entry stays full.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (wr_en) begin
      full <= 1'b1;
      data <= wr_data;
    end else if (rd_en) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/word_to_serial_msb_first.sv
// -----------------------------------------------------------------------------
// word_to_serial_msb_first
// Accepts a W-bit word over valid/ready and shifts it out MSB-first, one bit
// per clock, with first/last framing flags for a downstream serial checker.
//
// Optional build macro: WORD_TO_SERIAL_PREFETCH_EN
//   undefined : no buffering, one idle cycle between words (W+1 cycles/word)
//   defined   : one-entry prefetch buffer, back-to-back words (W cycles/word)
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : upstream word valid
//   in_ready   : stage can accept a word this cycle
//   in_data    : word, bit W-1 is serialized first
//   out_valid  : out_bit is meaningful this cycle
//   out_bit    : current serial bit
//   out_first  : out_bit is bit W-1 of a word
//   out_last   : out_bit is bit 0 of a word
//   busy       : a word is shifting, or one is buffered (prefetch build)
// -----------------------------------------------------------------------------
module word_to_serial_msb_first
  import word_to_serial_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic         out_bit,
  output logic         out_first,
  output logic         out_last,
  output logic         busy
);

  localparam int               CNT_W   = cnt_width(W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(W - 1);

  state_t           state, state_nxt;
  logic [W-1:0]     shreg, shreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             xfer;
  logic             cnt_zero;
  logic             shifting;
  logic             ready_int;

  assign xfer     = in_valid && in_ready;
  assign cnt_zero = (cnt == '0);
  assign shifting = !rst && (state == ST_SHIFT);

`ifdef WORD_TO_SERIAL_PREFETCH_EN
  logic         buf_full;
  logic         buf_wr;
  logic         buf_rd;
  logic [W-1:0] buf_data;

  // Accept whenever the buffer has room; an idle shifter takes the word
  // directly, a busy one parks it in the buffer.
  assign ready_int = !buf_full;

  // Fill the buffer on any transfer during ST_SHIFT, except in the cnt==0
  // cycle with an empty buffer: that word goes straight into the shifter.
  assign buf_wr = xfer && (state == ST_SHIFT) && !(cnt_zero && !buf_full);
  assign buf_rd = (state == ST_SHIFT) && cnt_zero && buf_full;

  word_to_serial_buf #(.W(W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_wr),
    .wr_data (in_data),
    .rd_en   (buf_rd),
    .full    (buf_full),
    .data    (buf_data)
  );

  assign busy = shifting || (!rst && buf_full);
`else
  assign ready_int = (state == ST_IDLE);
  assign busy      = shifting;
`endif

  // All outputs decode registered state; rst only forces them low.
  assign in_ready  = !rst && ready_int;
  assign out_valid = shifting;
  assign out_bit   = shifting && shreg[W-1];
  assign out_first = shifting && (cnt == CNT_MAX);
  assign out_last  = shifting && cnt_zero;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; that is what keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          shreg_nxt = in_data;
          cnt_nxt   = CNT_MAX;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_nxt = shreg << 1;
        if (!cnt_zero) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
`ifdef WORD_TO_SERIAL_PREFETCH_EN
          // Reload without leaving ST_SHIFT so the next word follows with
          // no bubble; a buffered word takes priority over the input.
          if (buf_full) begin
            shreg_nxt = buf_data;
            cnt_nxt   = CNT_MAX;
          end else if (xfer) begin
            shreg_nxt = in_data;
            cnt_nxt   = CNT_MAX;
          end else begin
            state_nxt = ST_IDLE;
          end
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_word_to_serial_msb_first.sv
// -----------------------------------------------------------------------------
// tb_word_to_serial_msb_first
// Directed bench for word_to_serial_msb_first (W=8 instance plus a W=1
// instance). Expectations follow WORD_TO_SERIAL_PREFETCH_EN when defined.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at that same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_word_to_serial_msb_first;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, out_valid, out_bit, out_first, out_last, busy;

  logic       in_valid1 = 1'b0;
  logic [0:0] in_data1 = 1'b0;
  logic       in_ready1, out_valid1, out_bit1, out_first1, out_last1, busy1;

  int checks = 0;
  int failures = 0;
  int rem5;

  always #5 clk = ~clk;

  word_to_serial_msb_first #(.W(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_first (out_first),
    .out_last  (out_last),
    .busy      (busy)
  );

  word_to_serial_msb_first #(.W(1)) u_w1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_data   (in_data1),
    .out_valid (out_valid1),
    .out_bit   (out_bit1),
    .out_first (out_first1),
    .out_last  (out_last1),
    .busy      (busy1)
  );

  // Serial mod-5 checker standing in for the downstream divisibility FSM:
  // cleared at out_first, remainder accumulated MSB-first.
  always @(posedge clk) begin
    if (rst) rem5 <= 0;
    else if (out_valid) rem5 <= (((out_first ? 0 : rem5) * 2) + int'(out_bit)) % 5;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a word and wait (bounded) for the handshake; returns in cycle 1.
  task automatic xfer_word(input logic [7:0] d, input string name);
    logic done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 32 && !done; i++) begin
      if (in_ready) done = 1'b1;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_handshake_timeout got=no_transfer exp=transfer", name);
    end
  endtask

  // Record 8 consecutive cycles; bit 7 of each mask is the first cycle.
  task automatic collect(output logic [7:0] bits, output logic [7:0] fm,
                         output logic [7:0] lm, output logic [7:0] vm,
                         output logic [7:0] rm, output logic [7:0] bm);
    bits = '0; fm = '0; lm = '0; vm = '0; rm = '0; bm = '0;
    for (int i = 0; i < 8; i++) begin
      bits[7-i] = out_bit;
      fm[7-i]   = out_first;
      lm[7-i]   = out_last;
      vm[7-i]   = out_valid;
      rm[7-i]   = in_ready;
      bm[7-i]   = busy;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    in_valid1 = 1'b1;
    in_data1 = 1'b1;
    step();
    step();
    checks++;
    if ({in_ready, out_valid, out_bit, out_first, out_last, busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000000",
               {in_ready, out_valid, out_bit, out_first, out_last, busy});
    end
    checks++;
    if ({in_ready1, out_valid1, out_bit1, out_first1, out_last1, busy1} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs_w1 got=%b exp=000000",
               {in_ready1, out_valid1, out_bit1, out_first1, out_last1, busy1});
    end
    rst = 1'b0;
    in_valid = 1'b0;
    in_valid1 = 1'b0;
    in_data1 = 1'b0;
    step();
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL idle_after_reset got={rdy,vld,busy}=%b exp=100",
               {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_a5();
    logic [7:0] bits, fm, lm, vm, rm, bm, exp_rm;
`ifdef WORD_TO_SERIAL_PREFETCH_EN
    exp_rm = 8'hFF;
`else
    exp_rm = 8'h00;
`endif
    xfer_word(8'hA5, "a5");
    collect(bits, fm, lm, vm, rm, bm);
    checks++;
    if (bits !== 8'hA5) begin
      failures++; $display("FAIL a5_bits got=%h exp=a5", bits);
    end
    checks++;
    if (vm !== 8'hFF) begin
      failures++; $display("FAIL a5_valid got=%b exp=11111111", vm);
    end
    checks++;
    if (fm !== 8'h80) begin
      failures++; $display("FAIL a5_first got=%b exp=10000000", fm);
    end
    checks++;
    if (lm !== 8'h01) begin
      failures++; $display("FAIL a5_last got=%b exp=00000001", lm);
    end
    checks++;
    if (rm !== exp_rm) begin
      failures++; $display("FAIL a5_ready got=%b exp=%b", rm, exp_rm);
    end
    checks++;
    if (bm !== 8'hFF) begin
      failures++; $display("FAIL a5_busy got=%b exp=11111111", bm);
    end
    checks++;
    if ({out_valid, out_bit, out_first, out_last, in_ready, busy} !== 6'b000010) begin
      failures++;
      $display("FAIL a5_after_word got=%b exp=000010",
               {out_valid, out_bit, out_first, out_last, in_ready, busy});
    end
  endtask

  task automatic test_div5();
    logic [7:0] bits, fm, lm, vm, rm, bm;
    xfer_word(8'd35, "div35");
    collect(bits, fm, lm, vm, rm, bm);
    checks++;
    if ((rem5 == 0) !== 1'b1) begin
      failures++; $display("FAIL div5_35 got=div_by_5=%0b exp=1", rem5 == 0);
    end
    xfer_word(8'd36, "div36");
    collect(bits, fm, lm, vm, rm, bm);
    checks++;
    if ((rem5 == 0) !== 1'b0) begin
      failures++; $display("FAIL div5_36 got=div_by_5=%0b exp=0", rem5 == 0);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] bits, fm, lm, vm, rm, bm;
    int stray;
    xfer_word(8'hFF, "mid_ff");
    step();
    step();
    step();
    checks++;
    if ({out_valid, out_bit, out_last} !== 3'b110) begin
      failures++;
      $display("FAIL mid_index4 got={vld,bit,last}=%b exp=110", {out_valid, out_bit, out_last});
    end
    rst = 1'b1;
    step();
    checks++;
    if ({in_ready, out_valid, out_bit, out_first, out_last, busy} !== 6'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%b exp=000000",
               {in_ready, out_valid, out_bit, out_first, out_last, busy});
    end
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid || out_last) stray++;
      step();
    end
    checks++;
    if (stray !== 0) begin
      failures++; $display("FAIL mid_no_completion got=%0d exp=0", stray);
    end
    xfer_word(8'h01, "mid_01");
    collect(bits, fm, lm, vm, rm, bm);
    checks++;
    if ({bits, fm, lm} !== {8'h01, 8'h80, 8'h01}) begin
      failures++;
      $display("FAIL mid_clean_frame got=bits %h first %b last %b exp=bits 01 first 10000000 last 00000001",
               bits, fm, lm);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] v, f, l, r, b;
    logic [17:0] ev, ef, el, er, eb;
    logic [7:0]  w1, w2;
    int s2;
    int sent;
    w1 = 8'h12;
    w2 = 8'h34;
`ifdef WORD_TO_SERIAL_PREFETCH_EN
    s2 = 8;
    ev = 18'h0FFFF;
    ef = 18'h00101;
    el = 18'h08080;
    er = 18'h3FF01;
`else
    s2 = 9;
    ev = 18'h1FEFF;
    ef = 18'h00201;
    el = 18'h10080;
    er = 18'h20100;
`endif
    eb = '0;
    for (int i = 0; i < 8; i++) begin
      eb[i]      = w1[7-i];
      eb[s2 + i] = w2[7-i];
    end
    v = '0; f = '0; l = '0; r = '0; b = '0;
    in_valid = 1'b1;
    in_data  = w1;
    step();
    in_data = w2;
    sent = 1;
    for (int c = 0; c < 18; c++) begin
      v[c] = out_valid;
      f[c] = out_first;
      l[c] = out_last;
      r[c] = in_ready;
      b[c] = out_bit;
      if (in_valid && in_ready) sent++;
      step();
      if (sent >= 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (sent !== 2) begin
      failures++; $display("FAIL b2b_words_sent got=%0d exp=2", sent);
    end
    checks++;
    if (v !== ev) begin
      failures++; $display("FAIL b2b_valid got=%h exp=%h", v, ev);
    end
    checks++;
    if (f !== ef) begin
      failures++; $display("FAIL b2b_first got=%h exp=%h", f, ef);
    end
    checks++;
    if (l !== el) begin
      failures++; $display("FAIL b2b_last got=%h exp=%h", l, el);
    end
    checks++;
    if (r !== er) begin
      failures++; $display("FAIL b2b_ready got=%h exp=%h", r, er);
    end
    checks++;
    if (b !== eb) begin
      failures++; $display("FAIL b2b_bits got=%h exp=%h", b, eb);
    end
  endtask

  task automatic test_w1();
    checks++;
    if (in_ready1 !== 1'b1) begin
      failures++; $display("FAIL w1_ready_idle got=%b exp=1", in_ready1);
    end
    in_valid1 = 1'b1;
    in_data1  = 1'b1;
    step();
    in_valid1 = 1'b0;
    in_data1  = 1'b0;
    checks++;
    if ({out_valid1, out_first1, out_last1, out_bit1} !== 4'b1111) begin
      failures++;
      $display("FAIL w1_frame got={vld,first,last,bit}=%b exp=1111",
               {out_valid1, out_first1, out_last1, out_bit1});
    end
    step();
    checks++;
    if ({out_valid1, out_last1, in_ready1} !== 3'b001) begin
      failures++;
      $display("FAIL w1_after got={vld,last,rdy}=%b exp=001", {out_valid1, out_last1, in_ready1});
    end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_div5();
    test_reset_mid_word();
    test_back_to_back();
    test_w1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/word_to_serial_msb_first.md
Name: word_to_serial_msb_first

Overview:
- Serializer stage directly upstream of the serial divisibility FSMs (serial_divisibility_by_3_using_fsm / _by_5_using_fsm).
- Accepts a W-bit word over a valid/ready handshake and emits it MSB-first, one bit per clock.
- Emits framing flags so the downstream checker can be cleared at word start and sampled at word end.

Parameters:
- W, 8, word width in bits; legal range 1..64.
- CNT_W, (W > 1) ? $clog2(W) : 1, bit-index counter width (derived; not to be overridden).

Ports:
- clk  input  1  clock
- rst  input  1  reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  stage can accept a word this cycle
- in_data  input  W  word, MSB is serialized first
- out_valid  output  1  out_bit is meaningful this cycle
- out_bit  output  1  current serial bit
- out_first  output  1  out_bit is bit W-1 of a word
- out_last  output  1  out_bit is bit 0 of a word
- busy  output  1  a word is being shifted, or one is buffered (prefetch build only)

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: state ST_IDLE, shift register 0, counter 0.
  - While rst is high: in_ready=0, out_valid=0, out_bit=0, out_first=0, out_last=0, busy=0.
  - Reset mid-word discards the word with no partial completion; out_last never fires for it.
- Handshake: transfer occurs at a posedge where in_valid && in_ready.
  - in_data is sampled only at that edge.
  - in_valid may drop without a transfer; no stability requirement is imposed on the upstream.
- FSM has two states.
  - ST_IDLE: in_ready=1, out_valid=0. On transfer: shreg<=in_data, cnt<=W-1, next state ST_SHIFT.
  - ST_SHIFT: out_valid=1, out_bit=shreg[W-1], out_first=(cnt==W-1), out_last=(cnt==0). Each cycle: shreg<=shreg<<1, cnt<=cnt-1. When cnt==0, next state is ST_IDLE (base build).
- Latency: word accepted at edge N; bit W-1 is visible in the cycle after edge N; bit 0 in cycle N+W.
- Throughput (base build): in_ready=0 throughout ST_SHIFT, so one word per W+1 cycles.
- All outputs are registered-state decodes; no combinational path from in_valid or in_data to any output.
- W=1: out_first and out_last are both high in the single ST_SHIFT cycle.
- The counter never wraps; ST_SHIFT is always left at cnt==0.
- Outputs outside ST_SHIFT: out_bit=0, out_first=0, out_last=0.

Optional Feature:
- Macro: WORD_TO_SERIAL_PREFETCH_EN.
- Defined: adds a one-entry word buffer (buf_data, buf_full).
  - in_ready = !rst && !buf_full, so the stage also accepts during ST_SHIFT.
  - Transfer in ST_IDLE loads shreg directly.
  - Transfer in ST_SHIFT fills the buffer.
  - In the cnt==0 cycle with buf_full (or a transfer in that same cycle), the buffered or incoming word loads into shreg with cnt<=W-1 and the FSM stays in ST_SHIFT.
  - Result: back-to-back words with zero bubble, one word per W cycles.
  - A simultaneous transfer and buffer drain in the cnt==0 cycle is legal.
  - busy includes buf_full.
- Undefined: no buffer; base behaviour above, with a mandatory 1-cycle gap between words.

Decomposition:
- Package word_to_serial_pkg holds:
  - the state enum type (ST_IDLE, ST_SHIFT; 1-bit encoding);
  - the function computing CNT_W from W.
- Optional sub-module word_to_serial_buf: one-entry valid/data holding register, instantiated only under WORD_TO_SERIAL_PREFETCH_EN.
- The FSM and shifter stay in the top module.

Test Plan:
- Reset then idle -> in_ready=1 and out_valid=0 on the first cycle after rst drops; all outputs 0 while rst is high.
- W=8, send 8'hA5 -> out_bit sequence 1,0,1,0,0,1,0,1 in cycles 1..8; out_first only in cycle 1, out_last only in cycle 8; in_ready=0 in cycles 1..8.
- Chain into serial_divisibility_by_5_using_fsm with its rst = rst | (out_valid & out_first & ~in-word bit); send 8'd35 -> div_by_5=1 after out_last; send 8'd36 -> div_by_5=0.
- Send 8'hFF then assert rst when out_bit index is 4 -> outputs drop to 0 next edge and no out_last occurs; then send 8'h01 -> clean frame whose only 1 is in the last bit.
- In_valid held high continuously with words 8'h12, 8'h34 -> base build: 1-cycle gap and in_ready pulses; prefetch build: no gap (out_last of the first word immediately followed by out_first of the second), in_ready low only while buf_full.
- W=1 build, send 1'b1 -> a single cycle with out_valid=out_first=out_last=out_bit=1.
